// File: rtl/mod_arith_pkg.sv
// Shared constants and FSM encoding for the modular-multiplier issue logic.
// The multiplier wrappers import the same package.
package mod_arith_pkg;

    localparam int DEF_WIDTH = 128;
    localparam int DEF_P     = 37;
    localparam int DEF_TAG_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_DRAIN
    } seq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers. It has one extra pointer bit to tell full from empty.
// There is no fall-through: a pushed word becomes visible the cycle after the push.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // NOTE: the storage array has no reset. Validity comes from the pointers alone, so the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values whatever the block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mod_mul_sequencer.sv
// Issue stage for the a*b mod P multiplier. It queues requests and launches one op at a time with a reset pulse,
// waits for a fresh done (with a timeout), and returns results in order on a valid/ready stream.
module mod_mul_sequencer
    import mod_arith_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int P       = DEF_P,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic             mm_reset,
    input  logic [WIDTH-1:0] mm_r,
    input  logic             mm_done,
    output logic             busy,
    output logic             err_range,
    output logic             err_tmo
);

    localparam int FW   = 2*WIDTH + TAG_W;
    localparam int RC_W = $clog2(RST_CYC + 1);
    localparam int TC_W = $clog2(TIMEOUT);
    localparam logic [WIDTH-1:0] P_W = WIDTH'(P);

    seq_state_e       state;
    seq_state_e       state_next;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FW-1:0]    fifo_dout;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [TAG_W-1:0] op_tag;
    logic [RC_W-1:0]  rst_cnt;
    logic [TC_W-1:0]  tmo_cnt;
    logic             armed;
    logic             out_free;
    logic             fire_done;
    logic             fire_tmo;
    logic             finish;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] hold_r;
    logic             hold_err;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign out_free = !out_valid || out_ready;
    assign mm_a     = op_a;
    assign mm_b     = op_b;
    assign finish   = fire_done || fire_tmo;
    assign res_r    = fire_done ? mm_r : '0;
    assign busy     = !fifo_empty || (state != ST_IDLE) || out_valid;

    sync_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({in_tag, in_b, in_a}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        mm_reset   = 1'b0;
        fire_done  = 1'b0;
        fire_tmo   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && out_free) begin
                    pop        = 1'b1;
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                mm_reset = 1'b1;
                if (rst_cnt == RC_W'(RST_CYC - 1)) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A real completion wins over a timeout that expires in the same cycle.
                fire_done = armed && mm_done;
                fire_tmo  = !fire_done && (tmo_cnt == TC_W'(TIMEOUT - 1));
                if (fire_done || fire_tmo) begin
                    state_next = out_free ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_free) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a      <= '0;
            op_b      <= '0;
            op_tag    <= '0;
            rst_cnt   <= '0;
            tmo_cnt   <= '0;
            armed     <= 1'b0;
            hold_r    <= '0;
            hold_err  <= 1'b0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
            err_range <= 1'b0;
            err_tmo   <= 1'b0;
        end else begin
            if (pop) begin
                {op_tag, op_b, op_a} <= fifo_dout;
            end

            if (state == ST_LAUNCH) begin
                rst_cnt <= rst_cnt + RC_W'(1);
                armed   <= 1'b0;
                tmo_cnt <= '0;
            end else begin
                rst_cnt <= '0;
            end

            // Arming on a low done ignores a done level left over from the previous op.
            if (state == ST_WAIT) begin
                tmo_cnt <= tmo_cnt + TC_W'(1);
                if (!mm_done) begin
                    armed <= 1'b1;
                end
            end

            if (finish && !out_free) begin
                hold_r   <= res_r;
                hold_err <= fire_tmo;
            end

            if (finish && out_free) begin
                out_valid <= 1'b1;
                out_r     <= res_r;
                out_tag   <= op_tag;
                out_err   <= fire_tmo;
            end else if ((state == ST_DRAIN) && out_free) begin
                out_valid <= 1'b1;
                out_r     <= hold_r;
                out_tag   <= op_tag;
                out_err   <= hold_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (fire_tmo) begin
                err_tmo <= 1'b1;
            end
            if (push && ((in_a >= P_W) || (in_b >= P_W))) begin
                err_range <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mod_mul_sequencer.sv
// Self-checking bench for mod_mul_sequencer. It uses a behavioural multiplier model, a table of request vectors,
// and a scoreboard queue that the output monitor drains.
module tb_mod_mul_sequencer;

    localparam int WIDTH   = 128;
    localparam int P       = 37;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 8;
    localparam int RST_CYC = 2;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] r;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_r;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic             mm_reset;
    logic [WIDTH-1:0] mm_r = '0;
    logic             mm_done = 1'b0;
    logic             busy;
    logic             err_range;
    logic             err_tmo;

    int   n_total = 0;
    int   n_pass  = 0;
    int   beats   = 0;
    exp_t sb[$];
    vec_t tv[7];

    // Multiplier model controls and state.
    int lat        = 20;
    bit stuck      = 1'b0;
    int stale_hold = 0;
    int m_cnt      = 0;
    bit m_active   = 1'b0;
    int m_stale    = 0;

    mod_mul_sequencer #(
        .WIDTH   (WIDTH),
        .P       (P),
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .RST_CYC (RST_CYC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_tag   (out_tag),
        .out_err   (out_err),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_reset  (mm_reset),
        .mm_r      (mm_r),
        .mm_done   (mm_done),
        .busy      (busy),
        .err_range (err_range),
        .err_tmo   (err_tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Multiplier model: done drops on launch (unless a stale level is being held), rises lat cycles into WAIT.
    always @(negedge clk) begin
        if (reset) begin
            mm_done  = 1'b0;
            mm_r     = '0;
            m_active = 1'b0;
        end else if (mm_reset) begin
            m_active = 1'b1;
            m_cnt    = 0;
            m_stale  = stale_hold;
            if (stale_hold == 0) mm_done = 1'b0;
        end else if (m_active) begin
            if (m_stale > 0) begin
                m_stale--;
                if (m_stale == 0) mm_done = 1'b0;
            end else if (!stuck) begin
                m_cnt++;
                if (m_cnt >= lat) begin
                    mm_r     = (mm_a * mm_b) % WIDTH'(P);
                    mm_done  = 1'b1;
                    m_active = 1'b0;
                end
            end
        end
    end

    // Output monitor: every completed handshake is compared with the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            exp_t e;
            beats++;
            check("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_r", out_r, e.r);
                check("out_tag", out_tag, e.tag);
                check("out_err", out_err, e.err);
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                        input logic [WIDTH-1:0] r, input logic err, input bit track, output int waits);
        bit accepted = 1'b0;
        waits    = 0;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        in_valid = 1'b1;
        while (!accepted && waits < 300) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                if (track) sb.push_back('{r: r, tag: tag, err: err});
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("send_accept", accepted, 1'b1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, (sb.size() == 0) && !busy, 1'b1);
    endtask

    // Ends on the first negedge of WAIT (mm_reset low again after a launch pulse).
    task automatic wait_launch(input string name);
        int n = 0;
        @(negedge clk);
        while (!mm_reset && n < 500) begin
            @(negedge clk);
            n++;
        end
        while (mm_reset && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(name, n < 500, 1'b1);
    endtask

    // Counts WAIT cycles without out_valid, starting at the current negedge.
    task automatic count_wait(output int n);
        n = 0;
        while (!out_valid && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_in_ready"}, in_ready, 1'b1);
        check({pfx, "_out_valid"}, out_valid, 1'b0);
        check({pfx, "_out_r"}, out_r, '0);
        check({pfx, "_out_tag_err"}, {out_tag, out_err}, '0);
        check({pfx, "_mm_reset"}, mm_reset, 1'b0);
        check({pfx, "_mm_ab"}, {mm_a, mm_b}, '0);
        check({pfx, "_busy"}, busy, 1'b0);
        check({pfx, "_flags"}, {err_range, err_tmo}, 2'b00);
    endtask

    initial begin
        int w;
        int wsum;
        int n;
        int resets_seen;
        int beats_before;
        logic [137:0] snap;

        tv[0] = '{a: 5,  b: 9,  tag: 8'hA5, r: 8};
        tv[1] = '{a: 3,  b: 4,  tag: 8'h11, r: 12};
        tv[2] = '{a: 6,  b: 7,  tag: 8'h12, r: 5};
        tv[3] = '{a: 10, b: 11, tag: 8'h13, r: 36};
        tv[4] = '{a: 36, b: 36, tag: 8'h14, r: 1};
        tv[5] = '{a: 0,  b: 25, tag: 8'h15, r: 0};
        tv[6] = '{a: 12, b: 13, tag: 8'h16, r: 8};

        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single op: launch timing, held operands, completion latency.
        send(tv[0].a, tv[0].b, tv[0].tag, tv[0].r, 1'b0, 1'b1, w);
        @(negedge clk);
        check("t1_pop_cycle_no_reset", mm_reset, 1'b0);
        for (int i = 0; i < RST_CYC; i++) begin
            @(negedge clk);
            check("t1_mm_reset_high", mm_reset, 1'b1);
        end
        check("t1_mm_operands", {mm_a, mm_b}, {tv[0].a, tv[0].b});
        @(negedge clk);
        check("t1_mm_reset_low", mm_reset, 1'b0);
        count_wait(n);
        check("t1_wait_cycles", n, lat);
        wait_drain("t1_drain");

        // Burst of six: five accepted back to back, the sixth stalls on a full FIFO.
        @(posedge clk);
        #1;
        wsum = 0;
        for (int i = 1; i <= 5; i++) begin
            send(tv[i].a, tv[i].b, tv[i].tag, tv[i].r, 1'b0, 1'b1, w);
            wsum += w;
        end
        check("burst_no_stall_first5", wsum, 0);
        @(negedge clk);
        check("burst_full_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        send(tv[6].a, tv[6].b, tv[6].tag, tv[6].r, 1'b0, 1'b1, w);
        check("burst_sixth_stalled", w > 0, 1'b1);
        wait_drain("burst_drain");
        check("no_range_err_below_p", err_range, 1'b0);

        // Backpressure: output held stable and no second launch while the output reg is occupied.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(2, 3, 8'hB0, 6, 1'b0, 1'b1, w);
        send(4, 5, 8'hB1, 20, 1'b0, 1'b1, w);
        n = 0;
        while (!out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", out_valid, 1'b1);
        snap = {out_valid, out_r, out_tag, out_err};
        resets_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("bp_stable", {out_valid, out_r, out_tag, out_err}, snap);
            if (mm_reset) resets_seen++;
        end
        check("bp_no_second_launch", resets_seen, 0);
        check("bp_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain("bp_drain");

        // Stale done: done stays high across the launch and for 10 WAIT cycles before dropping.
        check("stale_precondition", mm_done, 1'b1);
        stale_hold = 10;
        @(posedge clk);
        #1;
        send(9, 9, 8'hC0, 7, 1'b0, 1'b1, w);
        wait_launch("stale_launch");
        count_wait(n);
        check("stale_wait_cycles", n, 10 + lat);
        wait_drain("stale_drain");
        stale_hold = 0;

        // Timeout: done never rises, then the following op completes normally.
        stuck = 1'b1;
        @(posedge clk);
        #1;
        send(2, 2, 8'hD0, 0, 1'b1, 1'b1, w);
        wait_launch("tmo_launch");
        count_wait(n);
        check("tmo_wait_cycles", n, TIMEOUT);
        wait_drain("tmo_drain");
        check("tmo_sticky", err_tmo, 1'b1);
        stuck = 1'b0;
        @(posedge clk);
        #1;
        send(7, 8, 8'hD1, 19, 1'b0, 1'b1, w);
        wait_drain("after_tmo_drain");
        check("tmo_still_sticky", err_tmo, 1'b1);

        // Out-of-range operand, then reset in the middle of WAIT abandons the op.
        @(posedge clk);
        #1;
        send(40, 2, 8'hE0, 0, 1'b0, 1'b0, w);
        wait_launch("rng_launch");
        repeat (5) @(negedge clk);
        check("rng_err_range", err_range, 1'b1);
        check("rng_busy_in_wait", busy, 1'b1);
        beats_before = beats;
        #1 reset = 1'b1;
        #1;
        check_reset_state("midrst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        resets_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mm_reset) resets_seen++;
        end
        check("midrst_no_beat", beats, beats_before);
        check("midrst_no_launch", resets_seen, 0);
        check("midrst_idle", {busy, out_valid, err_range, err_tmo}, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
